// File: rtl/clock_set_ctrl.sv
// Clock set controller: turns hours/minutes set buttons into increment
// strobes, with hold-to-auto-repeat at a slow or fast strobe rate.
module clock_set_ctrl #(
  parameter int unsigned HOLD_TICKS = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_slow_stb,
  input  logic i_fast_stb,
  input  logic i_set_hours_db,
  input  logic i_set_minutes_db,
  input  logic i_fast_set_db,
  output logic o_hours_inc_stb,
  output logic o_minutes_inc_stb,
  output logic o_seconds_clr,
  output logic o_set_active
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  typedef enum logic {
    TGT_HOURS   = 1'b0,
    TGT_MINUTES = 1'b1
  } target_t;

  state_t           state_q, state_d;
  target_t          target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hours_inc_d, minutes_inc_d, seconds_clr_d, set_active_d;
  logic             fire;
  logic             tgt_btn;
  logic             rate_stb;

  // State, target, hold counter and registered output pulses
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q           <= ST_IDLE;
      target_q          <= TGT_HOURS;
      cnt_q             <= '0;
      o_hours_inc_stb   <= 1'b0;
      o_minutes_inc_stb <= 1'b0;
      o_seconds_clr     <= 1'b0;
      o_set_active      <= 1'b0;
    end else begin
      state_q           <= state_d;
      target_q          <= target_d;
      cnt_q             <= cnt_d;
      o_hours_inc_stb   <= hours_inc_d;
      o_minutes_inc_stb <= minutes_inc_d;
      o_seconds_clr     <= seconds_clr_d;
      o_set_active      <= set_active_d;
    end
  end

  // Next state and next-cycle output pulses
  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    cnt_d         = cnt_q;
    hours_inc_d   = 1'b0;
    minutes_inc_d = 1'b0;
    seconds_clr_d = 1'b0;
    fire          = 1'b0;
    tgt_btn       = (target_q == TGT_HOURS) ? i_set_hours_db : i_set_minutes_db;
    rate_stb      = i_fast_set_db ? i_fast_stb : i_slow_stb;

    case (state_q)
      ST_IDLE: begin
        // Hours wins a simultaneous press
        if (i_set_hours_db) begin
          target_d    = TGT_HOURS;
          state_d     = ST_HOLD;
          cnt_d       = '0;
          hours_inc_d = 1'b1;
        end else if (i_set_minutes_db) begin
          target_d      = TGT_MINUTES;
          state_d       = ST_HOLD;
          cnt_d         = '0;
          minutes_inc_d = 1'b1;
          seconds_clr_d = 1'b1;
        end
      end
      ST_HOLD: begin
        // Release beats any coincident strobe
        if (!tgt_btn) begin
          state_d = ST_IDLE;
        end else if (i_slow_stb) begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_REPEAT;
            fire    = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_REPEAT: begin
        if (!tgt_btn) begin
          state_d = ST_IDLE;
        end else if (rate_stb) begin
          fire = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fire) begin
      hours_inc_d   = (target_q == TGT_HOURS);
      minutes_inc_d = (target_q == TGT_MINUTES);
    end

    set_active_d = (state_d != ST_IDLE);
  end

endmodule
